// File: rtl/cpu_run_controller_pkg.sv
// Shared types and constants for the CPU run controller and its trace FIFO.
package cpu_run_controller_pkg;

  typedef enum logic [1:0] {
    StHold = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } run_state_e;

  typedef enum logic [1:0] {
    CauseNone    = 2'd0,
    CauseHalt    = 2'd1,
    CauseStall   = 2'd2,
    CauseTimeout = 2'd3
  } done_cause_e;

  // ECALL
  localparam logic [31:0] DefaultHaltInstr = 32'h0000_0073;

  // Trace entry layout is {pc, rd, data}.
  function automatic int unsigned trace_entry_w(input int unsigned xlen);
    return xlen + 5 + xlen;
  endfunction

endpackage

// File: rtl/run_trace_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO without a
// same-cycle pop is dropped and reported by a one-cycle overflow pulse.
module run_trace_fifo #(
  parameter int unsigned WIDTH = 69,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = pop && !empty;
    // A pop frees the slot on the same edge, so a full FIFO can still accept.
    do_push  = push && (!full || do_pop);
    overflow = push && full && !do_pop;
    pop_data = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/cpu_run_controller.sv
// Run controller beside the CPU: sequences CPU reset, counts RUN cycles and
// retirements, detects halt/stall/timeout and traces register writebacks.
module cpu_run_controller
  import cpu_run_controller_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned RST_HOLD    = 4,
  parameter int unsigned MAX_CYCLES  = 940,
  parameter int unsigned STALL_LIMIT = 16,
  parameter int unsigned TRACE_DEPTH = 8,
  parameter logic [31:0] HALT_INSTR  = DefaultHaltInstr
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  output logic             cpu_reset,
  input  logic             wb_valid,
  input  logic [31:0]      wb_instr,
  input  logic [XLEN-1:0]  wb_pc,
  input  logic             wb_reg_we,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic             trace_valid,
  input  logic             trace_ready,
  output logic [XLEN-1:0]  trace_pc,
  output logic [4:0]       trace_rd,
  output logic [XLEN-1:0]  trace_data,
  output logic             trace_ovf,
  output logic             done,
  output logic [1:0]       done_cause,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retired_count
);

  localparam int unsigned EntryW = trace_entry_w(XLEN);
  localparam int unsigned HoldW  = $clog2(RST_HOLD) + 1;
  localparam int unsigned IdleW  = $clog2(STALL_LIMIT) + 1;

  run_state_e       state_q, state_d;
  done_cause_e      cause_q, cause_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [IdleW-1:0] idle_q, idle_d, idle_inc;
  logic [CNT_W-1:0] cycle_q, cycle_d, cycle_inc;
  logic [CNT_W-1:0] retired_q, retired_d, retired_inc;
  logic             ovf_q;
  logic             halt_hit, stall_hit, timeout_hit;

  logic              fifo_push, fifo_full, fifo_empty, fifo_ovf;
  logic [EntryW-1:0] fifo_rdata;

  always_comb begin
    cycle_inc   = (&cycle_q) ? cycle_q : cycle_q + CNT_W'(1);
    retired_inc = (&retired_q) ? retired_q : retired_q + CNT_W'(1);
    idle_inc    = idle_q + IdleW'(1);
    halt_hit    = wb_valid && (wb_instr == HALT_INSTR);
    stall_hit   = !wb_valid && (idle_inc == IdleW'(STALL_LIMIT));
    timeout_hit = (cycle_inc == CNT_W'(MAX_CYCLES));
  end

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    hold_d    = hold_q;
    idle_d    = idle_q;
    cycle_d   = cycle_q;
    retired_d = retired_q;
    unique case (state_q)
      StHold: begin
        idle_d = '0;
        if (hold_q == HoldW'(RST_HOLD - 1)) begin
          state_d = StRun;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      StRun: begin
        cycle_d = cycle_inc;
        if (wb_valid) begin
          retired_d = retired_inc;
          idle_d    = '0;
        end else begin
          idle_d = idle_inc;
        end
        if (halt_hit || stall_hit || timeout_hit) state_d = StDone;
        if (halt_hit)         cause_d = CauseHalt;
        else if (stall_hit)   cause_d = CauseStall;
        else if (timeout_hit) cause_d = CauseTimeout;
      end
      StDone: begin
        if (restart) begin
          state_d   = StHold;
          cause_d   = CauseNone;
          hold_d    = '0;
          idle_d    = '0;
          cycle_d   = '0;
          retired_d = '0;
        end
      end
      default: state_d = StHold;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StHold;
      cause_q   <= CauseNone;
      hold_q    <= '0;
      idle_q    <= '0;
      cycle_q   <= '0;
      retired_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      hold_q    <= hold_d;
      idle_q    <= idle_d;
      cycle_q   <= cycle_d;
      retired_q <= retired_d;
      ovf_q     <= ovf_q | fifo_ovf;
    end
  end

  assign fifo_push = (state_q == StRun) && wb_valid && wb_reg_we && (wb_rd != 5'd0);

  run_trace_fifo #(
    .WIDTH (EntryW),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data ({wb_pc, wb_rd, wb_data}),
    .pop       (trace_ready),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .overflow  (fifo_ovf)
  );

  always_comb begin
    assert (!(fifo_full && fifo_empty));
  end

  assign cpu_reset     = (state_q == StHold);
  assign done          = (state_q == StDone);
  assign done_cause    = cause_q;
  assign cycle_count   = cycle_q;
  assign retired_count = retired_q;
  assign trace_ovf     = ovf_q;
  assign trace_valid   = !fifo_empty;
  assign trace_pc      = fifo_rdata[EntryW-1 -: XLEN];
  assign trace_rd      = fifo_rdata[XLEN +: 5];
  assign trace_data    = fifo_rdata[XLEN-1:0];

endmodule
